// File: rtl/joy_cond_pkg.sv
// Shared types, constants and helpers for the joystick axis conditioner.
package joy_cond_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AX0,
    AX1,
    AX2,
    AX3,
    PUB
  } fsm_state_t;

  typedef enum logic {
    MODE_ANALOG = 1'b0,
    MODE_DPAD   = 1'b1
  } axis_mode_t;

  localparam logic signed [7:0] AXIS_POS_MAX = 8'sd127;
  localparam logic signed [7:0] AXIS_NEG_MAX = 8'sh80;
  localparam logic signed [7:0] AXIS_CENTER  = 8'sd0;

  // The positive direction wins when both directions are held
  function automatic logic signed [7:0] dpad_target(input logic pos_bit, input logic neg_bit);
    if (pos_bit) return AXIS_POS_MAX;
    if (neg_bit) return AXIS_NEG_MAX;
    return AXIS_CENTER;
  endfunction

endpackage

// File: rtl/joy_axis_step.sv
// One conditioning step for a single axis: IIR smoothing for analog sticks,
// slew-limited ramp toward a target for DPad sticks. Purely combinational.
module joy_axis_step
  import joy_cond_pkg::*;
#(
  parameter int IIR_SHIFT = 2,
  parameter int SLEW_STEP = 8
) (
  input  axis_mode_t                     mode,
  input  logic                           clear,
  input  logic signed [8+IIR_SHIFT-1:0]  acc,
  input  logic signed [7:0]              in,
  input  logic signed [7:0]              target,
  output logic signed [8+IIR_SHIFT-1:0]  acc_next
);

  localparam int ACC_W = 8 + IIR_SHIFT;
  localparam logic signed [9:0] STEP = 10'(SLEW_STEP);

  logic signed [ACC_W:0] in_scaled;
  logic signed [ACC_W:0] acc_ext;
  logic signed [ACC_W:0] diff;
  logic        [ACC_W:0] diff_mag;
  logic signed [ACC_W:0] iir_next;
  logic signed [9:0]     cur_int;
  logic signed [9:0]     tgt_int;
  logic signed [9:0]     ramp_up;
  logic signed [9:0]     ramp_dn;
  logic signed [9:0]     slew_int;

  // Compute both candidate updates and pick one by mode; a mode change forces centre
  always_comb begin
    in_scaled = {in[7], in, {IIR_SHIFT{1'b0}}};
    acc_ext   = {acc[ACC_W-1], acc};
    diff      = in_scaled - acc_ext;
    diff_mag  = diff[ACC_W] ? $unsigned(-diff) : $unsigned(diff);
    if (diff_mag < (ACC_W+1)'(2 ** IIR_SHIFT)) begin
      iir_next = in_scaled;
    end else begin
      iir_next = acc_ext + (diff >>> IIR_SHIFT);
    end

    cur_int = {{2{acc[ACC_W-1]}}, acc[ACC_W-1 -: 8]};
    tgt_int = {{2{target[7]}}, target};
    ramp_up = cur_int + STEP;
    ramp_dn = cur_int - STEP;
    if (cur_int < tgt_int) begin
      slew_int = (ramp_up > tgt_int) ? tgt_int : ramp_up;
    end else if (cur_int > tgt_int) begin
      slew_int = (ramp_dn < tgt_int) ? tgt_int : ramp_dn;
    end else begin
      slew_int = tgt_int;
    end

    if (clear) begin
      acc_next = '0;
    end else if (mode == MODE_DPAD) begin
      acc_next = ACC_W'({slew_int, {IIR_SHIFT{1'b0}}});
    end else begin
      acc_next = ACC_W'(iir_next);
    end
  end

endmodule

// File: rtl/joy_axis_conditioner.sv
// Conditions raw stick inputs into signed 8-bit X/Y words for the game-port
// joystick block. One shared step unit walks the four axes once per tick and
// the results are published together.
module joy_axis_conditioner
  import joy_cond_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int IIR_SHIFT = 2,
  parameter int SLEW_STEP = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  joy_type,
  input  logic [3:0]  joy0_dir,
  input  logic [3:0]  joy1_dir,
  input  logic [15:0] joya0,
  input  logic [15:0] joya1,
  output logic [15:0] joya0_out,
  output logic [15:0] joya1_out,
  output logic        upd
);

  localparam int ACC_W = 8 + IIR_SHIFT;
  localparam int CNT_W = $clog2(TICK_DIV);

  fsm_state_t state, state_next;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  logic [1:0]  type_snap;
  logic [1:0]  last_type;
  logic [3:0]  dir0_snap;
  logic [3:0]  dir1_snap;
  logic [15:0] joya0_snap;
  logic [15:0] joya1_snap;

  logic signed [ACC_W-1:0] acc [4];

  logic                    axis_we;
  logic [1:0]              axis_idx;
  axis_mode_t              step_mode;
  logic                    step_clear;
  logic signed [7:0]       step_in;
  logic signed [7:0]       step_target;
  logic signed [ACC_W-1:0] step_acc;
  logic signed [ACC_W-1:0] step_next;

  assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

  // Free-running sample-rate divider
  always_ff @(posedge clk) begin
    if (reset || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // Freeze all inputs on the tick so every axis of a sequence sees one sample
  always_ff @(posedge clk) begin
    if (reset) begin
      type_snap  <= '0;
      dir0_snap  <= '0;
      dir1_snap  <= '0;
      joya0_snap <= '0;
      joya1_snap <= '0;
    end else if (tick && state == IDLE) begin
      type_snap  <= joy_type;
      dir0_snap  <= joy0_dir;
      dir1_snap  <= joy1_dir;
      joya0_snap <= joya0;
      joya1_snap <= joya1;
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and operand selection for the shared step unit
  always_comb begin
    state_next  = state;
    axis_we     = 1'b0;
    axis_idx    = 2'd0;
    step_mode   = MODE_ANALOG;
    step_clear  = 1'b0;
    step_in     = AXIS_CENTER;
    step_target = AXIS_CENTER;
    case (state)
      IDLE: if (tick) state_next = AX0;
      AX0: begin
        state_next  = AX1;
        axis_we     = 1'b1;
        axis_idx    = 2'd0;
        step_mode   = axis_mode_t'(type_snap[0]);
        step_clear  = type_snap[0] ^ last_type[0];
        step_in     = joya0_snap[7:0];
        step_target = dpad_target(dir0_snap[0], dir0_snap[1]);
      end
      AX1: begin
        state_next  = AX2;
        axis_we     = 1'b1;
        axis_idx    = 2'd1;
        step_mode   = axis_mode_t'(type_snap[0]);
        step_clear  = type_snap[0] ^ last_type[0];
        step_in     = joya0_snap[15:8];
        step_target = dpad_target(dir0_snap[2], dir0_snap[3]);
      end
      AX2: begin
        state_next  = AX3;
        axis_we     = 1'b1;
        axis_idx    = 2'd2;
        step_mode   = axis_mode_t'(type_snap[1]);
        step_clear  = type_snap[1] ^ last_type[1];
        step_in     = joya1_snap[7:0];
        step_target = dpad_target(dir1_snap[0], dir1_snap[1]);
      end
      AX3: begin
        state_next  = PUB;
        axis_we     = 1'b1;
        axis_idx    = 2'd3;
        step_mode   = axis_mode_t'(type_snap[1]);
        step_clear  = type_snap[1] ^ last_type[1];
        step_in     = joya1_snap[15:8];
        step_target = dpad_target(dir1_snap[2], dir1_snap[3]);
      end
      PUB:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign step_acc = acc[axis_idx];

  joy_axis_step #(
    .IIR_SHIFT (IIR_SHIFT),
    .SLEW_STEP (SLEW_STEP)
  ) u_step (
    .mode     (step_mode),
    .clear    (step_clear),
    .acc      (step_acc),
    .in       (step_in),
    .target   (step_target),
    .acc_next (step_next)
  );

  // Write back the selected axis accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) acc[i] <= '0;
    end else if (axis_we) begin
      acc[axis_idx] <= step_next;
    end
  end

  // Publish all four axes in one cycle and record the mode each stick used
  always_ff @(posedge clk) begin
    if (reset) begin
      joya0_out <= '0;
      joya1_out <= '0;
      upd       <= 1'b0;
      last_type <= '0;
    end else begin
      upd <= (state == PUB);
      if (state == PUB) begin
        joya0_out <= {acc[1][ACC_W-1 -: 8], acc[0][ACC_W-1 -: 8]};
        joya1_out <= {acc[3][ACC_W-1 -: 8], acc[2][ACC_W-1 -: 8]};
        last_type <= type_snap;
      end
    end
  end

  // The divider is long enough that a sequence always ends before the next tick
  assert property (@(posedge clk) disable iff (reset) tick |-> state == IDLE);

endmodule
